// File: rtl/lfsr_seq_checker.sv
// Self-check stage for a 4-bit x^4+x^3+1 LFSR stream: acquires lock, flywheels the
// expected value while locked, and flags/counts sequence errors with a saturating counter.
module lfsr_seq_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [3:0]           lfsr_i,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 zero_det,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [3:0] nxt(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  state_t               state, state_n;
  logic [3:0]           expected, expected_n;
  logic [3:0]           match_cnt, match_cnt_n;
  logic [3:0]           miss_cnt, miss_cnt_n;
  logic                 err_pulse_n, zero_det_n;
  logic [ERR_CNT_W-1:0] err_count_n;
  logic                 sample_zero;

  assign sample_zero = (lfsr_i == 4'd0);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    expected_n  = expected;
    match_cnt_n = match_cnt;
    miss_cnt_n  = miss_cnt;
    err_pulse_n = 1'b0;
    zero_det_n  = in_valid && sample_zero;

    if (in_valid) begin
      unique case (state)
        SEARCH: begin
          if (!sample_zero) begin
            expected_n  = nxt(lfsr_i);
            match_cnt_n = 4'd1;
            state_n     = VERIFY;
          end
        end
        VERIFY: begin
          if (sample_zero) begin
            match_cnt_n = 4'd0;
            state_n     = SEARCH;
          end else if (lfsr_i == expected) begin
            expected_n  = nxt(lfsr_i);
            match_cnt_n = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_C) begin
              miss_cnt_n = 4'd0;
              state_n    = LOCKED;
            end
          end else begin
            // Restart the run from this sample rather than dropping back to SEARCH.
            expected_n  = nxt(lfsr_i);
            match_cnt_n = 4'd1;
          end
        end
        LOCKED: begin
          expected_n = nxt(expected);
          if (lfsr_i == expected) begin
            miss_cnt_n = 4'd0;
          end else begin
            err_pulse_n = 1'b1;
            miss_cnt_n  = miss_cnt + 4'd1;
            if (miss_cnt + 4'd1 == LOSS_C) begin
              match_cnt_n = 4'd0;
              state_n     = SEARCH;
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end

    err_count_n = err_count;
    if (err_clr)
      err_count_n = '0;
    else if (err_pulse_n && err_count != CNT_MAX)
      err_count_n = err_count + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      expected  <= 4'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      err_pulse <= 1'b0;
      zero_det  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      expected  <= expected_n;
      match_cnt <= match_cnt_n;
      miss_cnt  <= miss_cnt_n;
      err_pulse <= err_pulse_n;
      zero_det  <= zero_det_n;
      err_count <= err_count_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule
